lut_n_hyst: RTL and testbench

- Successor to the fixed single-table clock-count lookup. Maps a measured period count (reference clocks per N sync periods) to a capacitor-bank state word.
- Corner thresholds and state words live in run-time loadable tables instead of compile-time include tables.
- Band changes pass through a programmable hysteresis window, so a slow frequency sweep near a corner does not chatter the bank.
- Sits between the period counter and the series/parallel switch drivers; one instance per bank.

---
 rtl/lut_n_hyst.sv | 209 ++++++++++++++++++++
 tb/tb_lut_n_hyst.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_n_hyst.sv
// Period-count to capacitor-bank state lookup with run-time loadable corner/state
// tables, a serial one-corner-per-clock scan and a hysteresis window on band changes.
module lut_n_hyst #(
  parameter int CNT_W     = 14,
  parameter int STATE_W   = 7,
  parameter int N_CORNERS = 16,
  parameter int ADDR_W    = 4,
  parameter int HYST      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CNT_W-1:0]   n_clk_cnts,
  input  logic               sample_valid,
  input  logic               tbl_we,
  input  logic               tbl_sel,
  input  logic [ADDR_W-1:0]  tbl_addr,
  input  logic [CNT_W-1:0]   tbl_wdata,
  output logic [STATE_W-1:0] state_out,
  output logic [ADDR_W-1:0]  band,
  output logic               in_range,
  output logic               out_valid,
  output logic               busy,
  output logic               overrun,
  output logic               tbl_err
);

  localparam int IDX_W = $clog2(N_CORNERS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CORNERS - 1);
  localparam logic [ADDR_W:0]  ADDR_LIM = (ADDR_W + 1)'(N_CORNERS);
  localparam logic [CNT_W:0]   HYST_X   = (CNT_W + 1)'(HYST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DECIDE = 2'd2
  } state_t;

  state_t state_r, state_nx_s;

  logic [CNT_W-1:0]   corner_r    [N_CORNERS];
  logic [STATE_W-1:0] state_tbl_r [N_CORNERS];

  logic [CNT_W-1:0]   n_r;
  logic [IDX_W-1:0]   j_r;
  logic [IDX_W-1:0]   acc_r;
  logic [IDX_W-1:0]   cur_r;
  logic               have_band_r;
  logic [STATE_W-1:0] state_out_r;
  logic               in_range_r;
  logic               out_valid_r;
  logic               busy_r;
  logic               overrun_r;
  logic               tbl_err_r;

  logic               start_s;
  logic               decide_s;
  logic               idle_s;
  logic               addr_ok_s;
  logic               wr_ok_s;
  logic [IDX_W-1:0]   widx_s;
  logic               hit_s;
  logic               in_range_s;
  logic [IDX_W-1:0]   cand_s;
  logic [IDX_W-1:0]   up_idx_s;
  logic [CNT_W:0]     n_x_s;
  logic [CNT_W:0]     up_lim_s;
  logic [CNT_W:0]     dn_lim_s;
  logic               accept_s;
  logic [IDX_W-1:0]   new_band_s;

  assign state_out = state_out_r;
  assign band      = ADDR_W'(cur_r);
  assign in_range  = in_range_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign overrun   = overrun_r;
  assign tbl_err   = tbl_err_r;

  assign idle_s    = (state_r == IDLE);
  assign addr_ok_s = ({1'b0, tbl_addr} < ADDR_LIM);
  assign wr_ok_s   = tbl_we & idle_s & addr_ok_s;
  assign widx_s    = tbl_addr[IDX_W-1:0];

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state and phase strobes
  always_comb begin
    state_nx_s = state_r;
    start_s    = 1'b0;
    decide_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (sample_valid) begin
          state_nx_s = SCAN;
          start_s    = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      SCAN: begin
        if (j_r == LAST_IDX) begin
          state_nx_s = DECIDE;
        end else begin
          state_nx_s = SCAN;
        end
      end
      DECIDE: begin
        state_nx_s = IDLE;
        decide_s   = 1'b1;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Corner comparison and hysteresis decision, all at CNT_W+1 bits so n+HYST cannot wrap
  always_comb begin
    hit_s      = (corner_r[j_r] >= n_r);
    in_range_s = ~(n_r > corner_r[0]);
    cand_s     = acc_r;
    n_x_s      = {1'b0, n_r};
    // cur+1 only matters when cand > cur, so cur is never the last band there
    if (cur_r == LAST_IDX) begin
      up_idx_s = cur_r;
    end else begin
      up_idx_s = cur_r + IDX_W'(1);
    end
    up_lim_s = {1'b0, corner_r[up_idx_s]};
    dn_lim_s = {1'b0, corner_r[cur_r]} + HYST_X;
    accept_s = 1'b0;
    if (!have_band_r) begin
      accept_s = 1'b1;
    end else if (cand_s > cur_r) begin
      accept_s = ((n_x_s + HYST_X) <= up_lim_s);
    end else if (cand_s < cur_r) begin
      accept_s = (n_x_s >= dn_lim_s);
    end else begin
      accept_s = 1'b0;
    end
    if (accept_s) begin
      new_band_s = cand_s;
    end else begin
      new_band_s = cur_r;
    end
  end

  // Table storage: not reset, written only while idle at a legal index
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      if (tbl_sel) begin
        state_tbl_r[widx_s] <= tbl_wdata[STATE_W-1:0];
      end else begin
        corner_r[widx_s] <= tbl_wdata;
      end
    end
  end

  // Sample latch, scan accumulator, decision outputs and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      n_r         <= {CNT_W{1'b0}};
      j_r         <= {IDX_W{1'b0}};
      acc_r       <= {IDX_W{1'b0}};
      cur_r       <= {IDX_W{1'b0}};
      have_band_r <= 1'b0;
      state_out_r <= {STATE_W{1'b0}};
      in_range_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      overrun_r   <= 1'b0;
      tbl_err_r   <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      if (start_s) begin
        n_r    <= n_clk_cnts;
        j_r    <= IDX_W'(1);
        acc_r  <= {IDX_W{1'b0}};
        busy_r <= 1'b1;
      end else if (state_r == SCAN) begin
        acc_r <= acc_r + IDX_W'(hit_s);
        j_r   <= j_r + IDX_W'(1);
      end else if (decide_s) begin
        cur_r       <= new_band_s;
        have_band_r <= 1'b1;
        in_range_r  <= in_range_s;
        out_valid_r <= 1'b1;
        busy_r      <= 1'b0;
        if (accept_s) begin
          state_out_r <= state_tbl_r[new_band_s];
        end
      end
      if (sample_valid && !idle_s) begin
        overrun_r <= 1'b1;
      end
      if (tbl_we && !(idle_s && addr_ok_s)) begin
        tbl_err_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lut_n_hyst.sv
// Randomised scoreboard bench for lut_n_hyst: a band/hysteresis reference model predicts
// each decision, a negedge monitor pops and compares on every out_valid pulse.
module tb_lut_n_hyst;

  localparam int CNT_W   = 14;
  localparam int STATE_W = 7;
  localparam int N_C     = 4;
  localparam int ADDR_W  = 4;
  localparam int HYST    = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [CNT_W-1:0]   n_clk_cnts;
  logic               sample_valid;
  logic               tbl_we;
  logic               tbl_sel;
  logic [ADDR_W-1:0]  tbl_addr;
  logic [CNT_W-1:0]   tbl_wdata;
  logic [STATE_W-1:0] state_out;
  logic [ADDR_W-1:0]  band;
  logic               in_range;
  logic               out_valid;
  logic               busy;
  logic               overrun;
  logic               tbl_err;

  lut_n_hyst #(
    .CNT_W(CNT_W), .STATE_W(STATE_W), .N_CORNERS(N_C), .ADDR_W(ADDR_W), .HYST(HYST)
  ) dut (
    .clk(clk), .rst(rst), .n_clk_cnts(n_clk_cnts), .sample_valid(sample_valid),
    .tbl_we(tbl_we), .tbl_sel(tbl_sel), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .state_out(state_out), .band(band), .in_range(in_range), .out_valid(out_valid),
    .busy(busy), .overrun(overrun), .tbl_err(tbl_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [STATE_W-1:0] st;
    logic [ADDR_W-1:0]  bd;
    logic               ir;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  int corner_m [N_C];
  int state_m  [N_C];
  int cur_m;
  int st_m;
  bit have_m;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    cur_m  = 0;
    st_m   = 0;
    have_m = 1'b0;
  endtask

  task automatic model_write(input bit sel, input int addr, input int data);
    if (addr < N_C) begin
      if (sel) state_m[addr] = data % 128;
      else corner_m[addr] = data;
    end
  endtask

  // Band = number of lower corners still >= n; a move needs HYST counts of margin past the edge.
  task automatic model_sample(input int n);
    int cand;
    bit acc;
    exp_t e;
    cand = 0;
    for (int j = 1; j < N_C; j++) if (corner_m[j] >= n) cand++;
    if (!have_m) acc = 1'b1;
    else if (cand > cur_m) acc = (n + HYST <= corner_m[cur_m + 1]);
    else if (cand < cur_m) acc = (n >= corner_m[cur_m] + HYST);
    else acc = 1'b0;
    if (acc) begin
      cur_m = cand;
      st_m  = state_m[cand];
    end
    have_m = 1'b1;
    e.st = STATE_W'(st_m);
    e.bd = ADDR_W'(cur_m);
    e.ir = (n <= corner_m[0]);
    exp_q.push_back(e);
  endtask

  // Monitor: every out_valid pulse consumes exactly one predicted result
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got 1 expected 0 (no pending sample)");
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_state_out", int'(state_out), int'(mon_e.st));
        chk("sb_band", int'(band), int'(mon_e.bd));
        chk("sb_in_range", int'(in_range), int'(mon_e.ir));
      end
    end
  end

  task automatic tbl_write(input bit sel, input int addr, input int data);
    @(negedge clk);
    tbl_we    = 1'b1;
    tbl_sel   = sel;
    tbl_addr  = ADDR_W'(addr);
    tbl_wdata = CNT_W'(data);
    @(posedge clk);
    #1;
    tbl_we = 1'b0;
    model_write(sel, addr, data);
  endtask

  task automatic wait_valid(input string name);
    int lat;
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no out_valid after %0d cycles expected pulse", name, lat);
    end
  endtask

  task automatic send_sample(input int n, input bit do_wr, input bit wsel, input int waddr,
                             input int wdata);
    int lat;
    @(negedge clk);
    n_clk_cnts   = CNT_W'(n);
    sample_valid = 1'b1;
    if (do_wr) begin
      tbl_we    = 1'b1;
      tbl_sel   = wsel;
      tbl_addr  = ADDR_W'(waddr);
      tbl_wdata = CNT_W'(wdata);
      model_write(wsel, waddr, wdata);
    end
    model_sample(n);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    tbl_we       = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
      chk("busy_during_lookup", int'(busy), 1);
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL latency_timeout: got no out_valid after %0d cycles expected %0d", lat, N_C);
    end
    chk("latency", lat, N_C);
    chk("busy_at_valid", int'(busy), 0);
  endtask

  task automatic chk_out(input string name, input int st, input int bd, input int ir);
    chk({name, "_state"}, int'(state_out), st);
    chk({name, "_band"}, int'(band), bd);
    chk({name, "_in_range"}, int'(in_range), ir);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_state_out"}, int'(state_out), 0);
    chk({name, "_band"}, int'(band), 0);
    chk({name, "_in_range"}, int'(in_range), 0);
    chk({name, "_out_valid"}, int'(out_valid), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_overrun"}, int'(overrun), 0);
    chk({name, "_tbl_err"}, int'(tbl_err), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int prev;
    int trans;
    int c0, c1, c2, c3, n, idx;

    rst          = 1'b1;
    n_clk_cnts   = '0;
    sample_valid = 1'b0;
    tbl_we       = 1'b0;
    tbl_sel      = 1'b0;
    tbl_addr     = '0;
    tbl_wdata    = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("reset");

    tbl_write(1'b0, 0, 5000);
    tbl_write(1'b0, 1, 3000);
    tbl_write(1'b0, 2, 2000);
    tbl_write(1'b0, 3, 1000);
    tbl_write(1'b1, 0, 'h11);
    tbl_write(1'b1, 1, 'h22);
    tbl_write(1'b1, 2, 'h44);
    tbl_write(1'b1, 3, 'h08);
    chk("tbl_err_after_load", int'(tbl_err), 0);

    send_sample(2500, 0, 0, 0, 0); chk_out("s2500", 'h22, 1, 1);
    send_sample(6000, 0, 0, 0, 0); chk_out("s6000", 'h11, 0, 0);
    send_sample(800, 0, 0, 0, 0);  chk_out("s800", 'h08, 3, 1);
    send_sample(2500, 0, 0, 0, 0); chk_out("back_to_b1", 'h22, 1, 1);
    send_sample(1998, 0, 0, 0, 0); chk_out("hold_1998", 'h22, 1, 1);
    send_sample(1996, 0, 0, 0, 0); chk_out("move_1996", 'h44, 2, 1);
    send_sample(2003, 0, 0, 0, 0); chk_out("hold_2003", 'h44, 2, 1);
    send_sample(2004, 0, 0, 0, 0); chk_out("move_2004", 'h22, 1, 1);
    send_sample(5000, 0, 0, 0, 0); chk_out("top_5000", 'h11, 0, 1);

    prev  = int'(band);
    trans = 0;
    for (int v = 4990; v >= 800; v -= 10) begin
      send_sample(v, 0, 0, 0, 0);
      if (int'(band) != prev) trans++;
      prev = int'(band);
    end
    chk("sweep_down_transitions", trans, 3);
    trans = 0;
    for (int v = 810; v <= 5000; v += 10) begin
      send_sample(v, 0, 0, 0, 0);
      if (int'(band) != prev) trans++;
      prev = int'(band);
    end
    chk("sweep_up_transitions", trans, 3);
    chk("overrun_before", int'(overrun), 0);

    // second sample one cycle later lands while busy and must be dropped
    @(negedge clk);
    n_clk_cnts   = CNT_W'(2500);
    sample_valid = 1'b1;
    model_sample(2500);
    @(negedge clk);
    n_clk_cnts = CNT_W'(1500);
    @(negedge clk);
    sample_valid = 1'b0;
    wait_valid("overrun_case");
    chk_out("overrun_result", 'h22, 1, 1);
    chk("overrun_flag", int'(overrun), 1);
    repeat (6) @(negedge clk);

    // corner write while busy must be ignored
    @(negedge clk);
    n_clk_cnts   = CNT_W'(2500);
    sample_valid = 1'b1;
    model_sample(2500);
    @(negedge clk);
    sample_valid = 1'b0;
    tbl_we       = 1'b1;
    tbl_sel      = 1'b0;
    tbl_addr     = ADDR_W'(1);
    tbl_wdata    = CNT_W'(100);
    @(negedge clk);
    tbl_we = 1'b0;
    wait_valid("busy_write_case");
    chk("tbl_err_busy_write", int'(tbl_err), 1);
    send_sample(2200, 0, 0, 0, 0); chk_out("table_intact", 'h22, 1, 1);

    // reset on the second scan cycle aborts the lookup
    @(negedge clk);
    n_clk_cnts   = CNT_W'(2500);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk_reset_outputs("midscan_rst");
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      chk("no_valid_after_abort", int'(out_valid), 0);
    end
    send_sample(2998, 0, 0, 0, 0); chk_out("first_after_rst", 'h22, 1, 1);

    send_sample(2650, 1, 0, 1, 2600); chk_out("write_and_sample", 'h11, 0, 1);
    tbl_write(1'b0, 1, 3000);
    chk("tbl_err_before_oob", int'(tbl_err), 0);
    tbl_write(1'b0, 7, 1500);
    chk("tbl_err_oob_addr", int'(tbl_err), 1);
    send_sample(1200, 0, 0, 0, 0); chk_out("after_oob_write", 'h44, 2, 1);

    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        c3 = int'($urandom_range(1, 2000));
        c2 = c3 + int'($urandom_range(1, 3000));
        c1 = c2 + int'($urandom_range(1, 3000));
        c0 = c1 + int'($urandom_range(1, 3000));
        tbl_write(1'b0, 0, c0);
        tbl_write(1'b0, 1, c1);
        tbl_write(1'b0, 2, c2);
        tbl_write(1'b0, 3, c3);
        for (int k = 0; k < N_C; k++) tbl_write(1'b1, k, int'($urandom_range(0, 16383)));
      end
      if ($urandom_range(0, 1) == 0) begin
        n = int'($urandom_range(0, 12000));
      end else begin
        idx = int'($urandom_range(0, N_C - 1));
        n = corner_m[idx] + int'($urandom_range(0, 16)) - 8;
        if (n < 0) n = 0;
      end
      send_sample(n, 0, 0, 0, 0);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
